// File: rtl/prog_rst_ctrl.sv
// Programming-reset controller: synchronises and debounces the programming button, then sequences
// prog_mode_o / prog_rst_no around a boot-programmer session. Optional WAIT_DONE timeout: PROG_TIMEOUT_EN.
module prog_rst_ctrl #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned HoldCycles     = 32,
  parameter int unsigned GuardCycles    = 4,
  parameter int unsigned TimeoutCycles  = 1048576
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic prog_btn_i,
  input  logic prog_done_i,
  output logic prog_rst_no,
  output logic prog_mode_o,
  output logic busy_o,
  output logic timeout_o
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

`ifdef PROG_TIMEOUT_EN
  localparam int unsigned MaxUsed = max2(max2(DebounceCycles, HoldCycles), max2(GuardCycles, TimeoutCycles));
`else
  localparam int unsigned MaxUsed = max2(max2(DebounceCycles, HoldCycles), GuardCycles);
`endif
  localparam int unsigned CntW = (MaxUsed > 32'd1) ? $clog2(MaxUsed) : 32'd1;

  localparam logic [CntW-1:0] CntOne   = CntW'(32'd1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DebounceCycles - 32'd1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 32'd1);
  localparam logic [CntW-1:0] GrdLast  = CntW'(GuardCycles - 32'd1);
`ifdef PROG_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLast  = CntW'(TimeoutCycles - 32'd1);
`endif

  if (SyncStages < 32'd2) begin : g_bad_sync
    $error("SyncStages must be at least 2");
  end
  if ((DebounceCycles < 32'd1) || (HoldCycles < 32'd1) || (GuardCycles < 32'd1) ||
      (TimeoutCycles < 32'd1)) begin : g_bad_cycles
    $error("cycle-count parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_HOLD      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_REARM     = 3'd5
  } state_e;

  logic [SyncStages-1:0] sync_r;
  logic                  btn_s;
  state_e                state_r, state_n;
  logic [CntW-1:0]       cnt_r, cnt_n;
  logic                  cnt_inc_s;
  logic                  rst_no_r, mode_r, busy_r;
`ifdef PROG_TIMEOUT_EN
  logic                  tmo_hit_s;
  logic                  timeout_r;
`endif

  // Button synchroniser chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SyncStages-2:0], prog_btn_i};
    end
  end

  assign btn_s = sync_r[SyncStages-1];

  // State and shared counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state decode; the counter clears on every transition
  always_comb begin
    state_n   = state_r;
    cnt_inc_s = 1'b0;
`ifdef PROG_TIMEOUT_EN
    tmo_hit_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (btn_s) begin
          state_n = ST_DEBOUNCE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        // A low btn_s wins over the final count: the press is rejected
        if (!btn_s) begin
          state_n = ST_IDLE;
        end else if (cnt_r == DebLast) begin
          state_n = ST_HOLD;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HoldLast) begin
          state_n = ST_WAIT_DONE;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (prog_done_i) begin
          state_n = ST_RELEASE;
        end else begin
`ifdef PROG_TIMEOUT_EN
          if (cnt_r == TmoLast) begin
            state_n   = ST_RELEASE;
            tmo_hit_s = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
`else
          state_n = ST_WAIT_DONE;
`endif
        end
      end
      ST_RELEASE: begin
        if (cnt_r == GrdLast) begin
          state_n = ST_REARM;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_REARM: begin
        if (!btn_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_REARM;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (state_n != state_r) begin
      cnt_n = '0;
    end else if (cnt_inc_s) begin
      cnt_n = cnt_r + CntOne;
    end else begin
      cnt_n = cnt_r;
    end
  end

  // Outputs are registered from the next state so they switch on the entry edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_no_r <= 1'b1;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      rst_no_r <= !((state_n == ST_HOLD) || (state_n == ST_WAIT_DONE) || (state_n == ST_RELEASE));
      mode_r   <= (state_n == ST_HOLD) || (state_n == ST_WAIT_DONE);
      busy_r   <= (state_n != ST_IDLE);
    end
  end

  assign prog_rst_no = rst_no_r;
  assign prog_mode_o = mode_r;
  assign busy_o      = busy_r;

`ifdef PROG_TIMEOUT_EN
  // Sticky timeout flag, cleared when a new session enters HOLD
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_r <= 1'b0;
    end else if ((state_n == ST_HOLD) && (state_r != ST_HOLD)) begin
      timeout_r <= 1'b0;
    end else if (tmo_hit_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign timeout_o = timeout_r;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_prog_rst_ctrl.sv
// Self-checking bench for prog_rst_ctrl: directed sessions plus random button/done traffic
// compared every cycle against a timestamp-based reference model.
module tb_prog_rst_ctrl;

  localparam int S     = 2;
  localparam int DEB   = 16;
  localparam int HOLDC = 32;
  localparam int GUARD = 4;
  localparam int TMO   = 64;
`ifdef PROG_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic btn = 1'b0;
  logic done = 1'b0;
  logic prog_rst_no, prog_mode_o, busy_o, timeout_o;

  prog_rst_ctrl #(
    .SyncStages(S), .DebounceCycles(DEB), .HoldCycles(HOLDC),
    .GuardCycles(GUARD), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .prog_btn_i(btn), .prog_done_i(done),
    .prog_rst_no(prog_rst_no), .prog_mode_o(prog_mode_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: session phases with entry timestamps
  typedef enum int {P_IDLE, P_DEB, P_HOLD, P_WAIT, P_REL, P_REARM} phase_t;
  phase_t ph;
  int     cyc;
  int     t_in;
  bit     tmo_m;
  bit     sh [S];

  task automatic model_reset();
    ph = P_IDLE; cyc = 0; t_in = 0; tmo_m = 1'b0;
    for (int i = 0; i < S; i++) sh[i] = 1'b0;
  endtask

  task automatic model_edge(input bit b_in, input bit d_in);
    bit b;
    b = sh[S-1];
    cyc++;
    for (int i = S - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = b_in;
    case (ph)
      P_IDLE:  if (b) begin ph = P_DEB; t_in = cyc; end
      P_DEB:   if (!b) ph = P_IDLE;
               else if (cyc - t_in == DEB) begin ph = P_HOLD; t_in = cyc; tmo_m = 1'b0; end
      P_HOLD:  if (cyc - t_in == HOLDC) begin ph = P_WAIT; t_in = cyc; end
      P_WAIT:  if (d_in) begin ph = P_REL; t_in = cyc; end
               else if (TMO_EN && (cyc - t_in == TMO)) begin ph = P_REL; t_in = cyc; tmo_m = 1'b1; end
      P_REL:   if (cyc - t_in == GUARD) begin ph = P_REARM; t_in = cyc; end
      P_REARM: if (!b) ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic step();
    bit in_rst;
    @(posedge clk);
    model_edge(btn, done);
    #1;
    in_rst = (ph == P_HOLD) || (ph == P_WAIT) || (ph == P_REL);
    check_eq("prog_rst_no", {31'd0, prog_rst_no}, {31'd0, !in_rst});
    check_eq("prog_mode_o", {31'd0, prog_mode_o}, {31'd0, (ph == P_HOLD) || (ph == P_WAIT)});
    check_eq("busy_o", {31'd0, busy_o}, {31'd0, ph != P_IDLE});
    check_eq("timeout_o", {31'd0, timeout_o}, {31'd0, tmo_m});
  endtask

  task automatic run_until(input phase_t p, input string tag);
    int k;
    k = 0;
    while ((ph != p) && (k < 200)) begin
      step();
      k++;
    end
    if (ph != p) check_eq(tag, 32'(ph), 32'(p));
  endtask

  int  burst;
  bit  saw_low;
  int  wlen;

  initial begin
    model_reset();
    #2 rst_ni = 1'b0;
    #1;
    check_eq("reset_rst_no", {31'd0, prog_rst_no}, 32'd1);
    check_eq("reset_mode", {31'd0, prog_mode_o}, 32'd0);
    check_eq("reset_busy", {31'd0, busy_o}, 32'd0);
    check_eq("reset_timeout", {31'd0, timeout_o}, 32'd0);
    @(posedge clk); @(posedge clk);
    #2 rst_ni = 1'b1;

    // Full session with fixed edge expectations
    for (int e = 1; e <= 212; e++) begin
      btn  = (e <= 100);
      done = (e == 200);
      step();
      if (e == 18) check_eq("pre_hold_rst", {31'd0, prog_rst_no}, 32'd1);
      if (e == 19) begin
        check_eq("hold_rst_fall", {31'd0, prog_rst_no}, 32'd0);
        check_eq("hold_mode_rise", {31'd0, prog_mode_o}, 32'd1);
      end
      if (e == 199) check_eq("mode_before_done", {31'd0, prog_mode_o}, 32'd1);
      if (e == 200) begin
        check_eq("mode_fall_done", {31'd0, prog_mode_o}, 32'd0);
        check_eq("rst_held_release", {31'd0, prog_rst_no}, 32'd0);
      end
      if (e == 203) check_eq("guard_rst_low", {31'd0, prog_rst_no}, 32'd0);
      if (e == 204) check_eq("guard_rst_rise", {31'd0, prog_rst_no}, 32'd1);
      if (e == 212) check_eq("session_idle", {31'd0, busy_o}, 32'd0);
    end
    done = 1'b0;

    // Glitch rejection
    saw_low = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      btn = (e <= 10);
      step();
      if (!prog_rst_no) saw_low = 1'b1;
    end
    check_eq("glitch_no_hold", {31'd0, saw_low}, 32'd0);
    check_eq("glitch_idle", {31'd0, busy_o}, 32'd0);

    // Early done ignored, held button parks in REARM
    btn = 1'b1;
    run_until(P_HOLD, "reach_hold");
    repeat (5) step();
    done = 1'b1; step(); done = 1'b0;
    check_eq("early_done_ignored", {31'd0, prog_mode_o}, 32'd1);
    run_until(P_WAIT, "reach_wait");
    repeat (10) step();
    done = 1'b1; step(); done = 1'b0;
    check_eq("wait_done_release", {31'd0, prog_mode_o}, 32'd0);
    repeat (60) step();
    check_eq("rearm_rst_high", {31'd0, prog_rst_no}, 32'd1);
    check_eq("rearm_busy", {31'd0, busy_o}, 32'd1);
    check_eq("rearm_no_session", {31'd0, prog_mode_o}, 32'd0);
    btn = 1'b0;
    repeat (4) step();
    check_eq("rearm_to_idle", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset mid-session
    btn = 1'b1;
    repeat (30) step();
    btn = 1'b0;
    run_until(P_WAIT, "reach_wait_rst");
    repeat (5) step();
    #2 rst_ni = 1'b0;
    #1;
    check_eq("midrst_rst_no", {31'd0, prog_rst_no}, 32'd1);
    check_eq("midrst_mode", {31'd0, prog_mode_o}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst_ni = 1'b1;
    repeat (3) step();
    check_eq("midrst_idle", {31'd0, busy_o}, 32'd0);

`ifdef PROG_TIMEOUT_EN
    // Timeout and its clearing on the next HOLD entry
    btn = 1'b1;
    run_until(P_WAIT, "tmo_reach_wait");
    btn = 1'b0;
    wlen = 0;
    while (prog_mode_o && (wlen < 100)) begin
      step();
      wlen++;
    end
    check_eq("tmo_latency", 32'(wlen), 32'(TMO));
    check_eq("tmo_flag_set", {31'd0, timeout_o}, 32'd1);
    repeat (8) step();
    btn = 1'b1;
    run_until(P_HOLD, "tmo_reach_hold");
    check_eq("tmo_flag_clear", {31'd0, timeout_o}, 32'd0);
    // Done on the exact timeout cycle wins
    run_until(P_WAIT, "tie_reach_wait");
    btn = 1'b0;
    repeat (TMO - 1) step();
    done = 1'b1; step(); done = 1'b0;
    check_eq("tie_mode_fall", {31'd0, prog_mode_o}, 32'd0);
    check_eq("tie_no_timeout", {31'd0, timeout_o}, 32'd0);
    repeat (10) step();
`endif

    // Random button bursts and done pulses
    burst = 0;
    for (int e = 0; e < 4000; e++) begin
      if (burst == 0) begin
        btn   = $urandom_range(0, 1);
        burst = $urandom_range(1, 40);
      end else begin
        burst--;
      end
      done = ($urandom_range(0, 15) == 0);
      step();
    end
    done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
